// File: rtl/mem_copy_engine.sv
// mem_copy_engine: single-port bus master executing block copy and block fill
// commands on byte memory. Each copied byte costs one read cycle followed by
// one write cycle because the memory has a single shared address.
// All memory-side and status outputs are registered so they are glitch-free.

module mem_copy_engine #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          CLK,
    input  logic          reset_n,
    input  logic          start,
    input  logic          fill,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW-1:0] len,
    input  logic [DW-1:0] fill_val,
    input  logic          abort,
    output logic [AW-1:0] mem_addr,
    output logic          mem_read,
    output logic          mem_write,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic [AW-1:0] remaining
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [AW-1:0] ZERO_A = {AW{1'b0}};
    localparam logic [AW-1:0] ONE_A  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] ZERO_D = {DW{1'b0}};

    // Control and datapath state
    state_t        state_r;
    logic [AW-1:0] src_ptr_r;
    logic [AW-1:0] dst_ptr_r;
    logic [AW-1:0] count_r;
    logic [DW-1:0] buf_r;
    logic          fill_mode_r;
    logic [DW-1:0] fill_val_r;

    // Registered outputs
    logic [AW-1:0] mem_addr_r;
    logic          mem_read_r;
    logic          mem_write_r;
    logic [DW-1:0] mem_wdata_r;
    logic          busy_r;
    logic          done_r;
    logic          aborted_r;
    logic [AW-1:0] remaining_r;

    // Next-state values
    state_t        next_state_s;
    logic [AW-1:0] src_ptr_next_s;
    logic [AW-1:0] dst_ptr_next_s;
    logic [AW-1:0] count_next_s;
    logic [DW-1:0] buf_next_s;
    logic          fill_mode_next_s;
    logic [DW-1:0] fill_val_next_s;
    logic          abort_hit_s;
    logic          done_entry_s;

    // Next-state and datapath update decode for the command sequencer
    always_comb begin
        next_state_s     = state_r;
        src_ptr_next_s   = src_ptr_r;
        dst_ptr_next_s   = dst_ptr_r;
        count_next_s     = count_r;
        buf_next_s       = buf_r;
        fill_mode_next_s = fill_mode_r;
        fill_val_next_s  = fill_val_r;
        abort_hit_s      = 1'b0;

        case (state_r)
            IDLE: begin
                if (start) begin
                    src_ptr_next_s   = src;
                    dst_ptr_next_s   = dst;
                    count_next_s     = len;
                    fill_mode_next_s = fill;
                    fill_val_next_s  = fill_val;
                    if (len == ZERO_A) begin
                        next_state_s = DONE;
                    end else if (fill) begin
                        next_state_s = WR;
                    end else begin
                        next_state_s = RD;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end

            RD: begin
                // An abort here suppresses the pending write entirely
                if (abort) begin
                    abort_hit_s  = 1'b1;
                    next_state_s = DONE;
                end else begin
                    buf_next_s   = mem_rdata;
                    next_state_s = WR;
                end
            end

            WR: begin
                // The write in this cycle always commits, even under abort
                dst_ptr_next_s = dst_ptr_r + ONE_A;
                count_next_s   = count_r - ONE_A;
                if (fill_mode_r) begin
                    src_ptr_next_s = src_ptr_r;
                end else begin
                    src_ptr_next_s = src_ptr_r + ONE_A;
                end
                if (abort) begin
                    abort_hit_s  = 1'b1;
                    next_state_s = DONE;
                end else if (count_r == ONE_A) begin
                    next_state_s = DONE;
                end else if (fill_mode_r) begin
                    next_state_s = WR;
                end else begin
                    next_state_s = RD;
                end
            end

            DONE: begin
                next_state_s = IDLE;
            end

            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    assign done_entry_s = (next_state_s == DONE) && (state_r != DONE);

    // State and datapath registers
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            src_ptr_r   <= ZERO_A;
            dst_ptr_r   <= ZERO_A;
            count_r     <= ZERO_A;
            buf_r       <= ZERO_D;
            fill_mode_r <= 1'b0;
            fill_val_r  <= ZERO_D;
        end else begin
            state_r     <= next_state_s;
            src_ptr_r   <= src_ptr_next_s;
            dst_ptr_r   <= dst_ptr_next_s;
            count_r     <= count_next_s;
            buf_r       <= buf_next_s;
            fill_mode_r <= fill_mode_next_s;
            fill_val_r  <= fill_val_next_s;
        end
    end

    // Memory port outputs registered from the upcoming state; address and
    // write data hold their last values outside RD/WR
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            mem_addr_r  <= ZERO_A;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            mem_wdata_r <= ZERO_D;
        end else begin
            mem_read_r  <= (next_state_s == RD);
            mem_write_r <= (next_state_s == WR);
            if (next_state_s == RD) begin
                mem_addr_r <= src_ptr_next_s;
            end else if (next_state_s == WR) begin
                mem_addr_r <= dst_ptr_next_s;
            end else begin
                mem_addr_r <= mem_addr_r;
            end
            if (next_state_s == WR) begin
                mem_wdata_r <= fill_mode_next_s ? fill_val_next_s : buf_next_s;
            end else begin
                mem_wdata_r <= mem_wdata_r;
            end
        end
    end

    // Status outputs; completion status is captured on entry to DONE and
    // then held until the next command completes
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            aborted_r   <= 1'b0;
            remaining_r <= ZERO_A;
        end else begin
            busy_r <= (next_state_s != IDLE);
            done_r <= (next_state_s == DONE);
            if (done_entry_s) begin
                aborted_r   <= abort_hit_s;
                remaining_r <= count_next_s;
            end else begin
                aborted_r   <= aborted_r;
                remaining_r <= remaining_r;
            end
        end
    end

    assign mem_addr  = mem_addr_r;
    assign mem_read  = mem_read_r;
    assign mem_write = mem_write_r;
    assign mem_wdata = mem_wdata_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign aborted   = aborted_r;
    assign remaining = remaining_r;

endmodule

// File: doc/mem_copy_engine.md
# mem_copy_engine

Bus-master block that initiates read and write accesses on the single-port data memory interface (one shared address, combinational read data, write committed at the clock edge). It executes block copy and block fill commands on byte memory. It sits between the control unit, which issues `start` with source/destination/length, and the data memory port. Because there is one address pointer, each copied byte takes one read cycle followed by one write cycle.

## Interface
Parameters
- AW, 8, memory address width; addresses wrap modulo 2^AW
- DW, 8, data width

Ports
- CLK  in  1  system clock; all state changes on rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  command strobe, sampled only in IDLE
- fill  in  1  command mode: 0 = copy src→dst, 1 = fill dst with `fill_val`
- src  in  AW  source start address (ignored when fill=1)
- dst  in  AW  destination start address
- len  in  AW  byte count; 0 = no-op
- fill_val  in  DW  fill constant
- abort  in  1  terminate the active command
- mem_addr  out  AW  address to data memory
- mem_read  out  1  read enable to data memory
- mem_write  out  1  write enable to data memory
- mem_wdata  out  DW  write data to data memory
- mem_rdata  in  DW  combinational read data from data memory
- busy  out  1  high from the cycle after an accepted start until DONE exits
- done  out  1  one-cycle completion pulse
- aborted  out  1  valid with `done`: 1 if the command ended by abort
- remaining  out  AW  bytes not yet written at completion; 0 on normal finish

## Operation
- States: IDLE, RD, WR, DONE.
- IDLE: if start=1, latch src, dst, len, fill, and fill_val. If len=0, go to DONE. Otherwise go to RD for copy or WR for fill. `start` in any other state is ignored and not queued.
- RD: mem_addr=src_ptr, mem_read=1. At the edge, latch mem_rdata into buf, then go to WR.
- WR: mem_addr=dst_ptr, mem_write=1, mem_wdata=buf (copy) or fill_val (fill). At the edge the write commits, dst_ptr++, src_ptr++ (copy), and count--.
  - If count becomes 0, go to DONE.
  - Otherwise go to RD (copy) or stay in WR (fill).
- DONE: done=1 for one cycle, then go to IDLE.
- Pointers increment modulo 2^AW, so 0xFF+1 = 0x00. A copy crossing the top of memory wraps.
- Copy is strictly ascending. When dst lies in (src, src+len), already-written bytes are re-read. This is defined behaviour: the first (dst−src) bytes replicate.
- abort=1 in RD: no write occurs, go to DONE.
- abort=1 in WR: the write in that cycle still commits and the counters update, then go to DONE.
- abort in IDLE or DONE has no effect.
- aborted and remaining are held stable from DONE until the next accepted start.
- Outside RD and WR: mem_read=0, mem_write=0, and mem_addr and mem_wdata hold their last values.

## Timing
- Reset (asynchronous, reset_n=0) takes effect immediately:
  - State goes to IDLE.
  - mem_addr=0, mem_read=0, mem_write=0, mem_wdata=0, busy=0, done=0, aborted=0, remaining=0.
  - Reset mid-command drops the command. A write whose edge has not yet occurred is not performed.
- Start accepted at edge T:
  - Copy of N: RD/WR pairs occupy cycles T+1..T+2N, done is at T+2N+1, and busy is high for 2N+1 cycles.
  - Fill of N: WR occupies T+1..T+N, and done is at T+N+1.
  - len=0: done at T+1, with no memory access.
- Earliest next start is accepted at the edge ending the DONE cycle's successor (IDLE). Back-to-back commands are therefore separated by one IDLE cycle.
- mem_* outputs are registered state decodes and are glitch-free within a cycle. mem_rdata is sampled only at the edge ending an RD cycle.

## Test plan
- Copy: preload M[0x10..0x13]=A1,B2,C3,D4; start src=0x10 dst=0x40 len=4 → M[0x40..0x43]=A1,B2,C3,D4; done at T+9; remaining=0; aborted=0.
- Fill wrap: dst=0xFE len=3 fill_val=0x5A → M[0xFE],M[0xFF],M[0x00]=5A; done at T+4; M[0x01] unchanged.
- Overlap: M[0x20]=11, M[0x21]=22; copy src=0x20 dst=0x21 len=2 → M[0x21]=11, M[0x22]=11.
- Abort: copy len=8; assert abort during the 3rd WR cycle → exactly 3 bytes written; done on the next cycle; aborted=1; remaining=5.
- Edge cases: len=0 → done at T+1 with no mem_read or mem_write; start pulsed while busy is ignored, leaving dst of the running command and cycle count unchanged.
- Async reset: drop reset_n mid-RD with no clock → all outputs are zero immediately; after release, a new start executes normally.
